// File: rtl/mem_bridge.sv
// Multicycle-CPU to word-memory handshake bridge (IDLE/REQ/DONE) with a sticky error flag.
// Optional REQ-phase timeout is compiled in with `define MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT must lie in 2..255");
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic [CW-1:0] cnt;
`endif

  // Controller must freeze as soon as a request is seen, hence combinational.
  assign stall = ((state == IDLE) && cpu_req) || (state == REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            mem_addr  <= cpu_addr[31:2];
            mem_wdata <= cpu_wdata;
            if (cpu_addr[1:0] == 2'b00) begin
              state   <= REQ;
              mem_req <= 1'b1;
              mem_we  <= cpu_we;
`ifdef MEM_BRIDGE_TIMEOUT_EN
              cnt     <= '0;
`endif
            end else begin
              // Misaligned: never touch memory, complete immediately with error.
              state    <= DONE;
              cpu_done <= 1'b1;
              err      <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state    <= DONE;
            cpu_done <= 1'b1;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if (!mem_we) cpu_rdata <= mem_rdata;
          end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state    <= DONE;
            cpu_done <= 1'b1;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            err      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge; outputs sampled on the falling clock edge.
module tb_mem_bridge;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_bridge #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    cyc(); cyc();
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_mem_we",    32'(mem_we),    32'h0);
    chk("rst_cpu_done",  32'(cpu_done),  32'h0);
    chk("rst_err",       32'(err),       32'h0);
    chk("rst_cpu_rdata", cpu_rdata,      32'h0);
    chk("rst_mem_addr",  32'(mem_addr),  32'h0);
    chk("rst_mem_wdata", mem_wdata,      32'h0);
    chk("rst_stall",     32'(stall),     32'h0);
    reset = 1'b1;
    cyc();

    // Aligned read, ack in first REQ cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010; #1;
    chk("rd_stall_idle", 32'(stall), 32'h1);
    cyc();
    chk("rd_mem_req",  32'(mem_req),  32'h1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h4);
    chk("rd_mem_we",   32'(mem_we),   32'h0);
    chk("rd_done_t1",  32'(cpu_done), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    cyc();
    chk("rd_done_t2",  32'(cpu_done), 32'h1);
    chk("rd_rdata",    cpu_rdata,     32'h1234_5678);
    chk("rd_err",      32'(err),      32'h0);
    chk("rd_stall_dn", 32'(stall),    32'h0);
    chk("rd_req_drop", 32'(mem_req),  32'h0);
    cpu_req = 1'b0; mem_ack = 1'b0;
    cyc();
    chk("rd_done_once", 32'(cpu_done), 32'h0);

    // Spurious ack in IDLE must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    cyc();
    chk("sp_rdata",   cpu_rdata,        32'h1234_5678);
    chk("sp_mem_req", 32'(mem_req),     32'h0);
    chk("sp_done",    32'(cpu_done),    32'h0);
    mem_ack = 1'b0;
    cyc();

    // Write with five wait cycles; cpu_* wiggle mid-flight.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'hCAFE_F00D;
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("wr_mem_req",   32'(mem_req),  32'h1);
      chk("wr_mem_we",    32'(mem_we),   32'h1);
      chk("wr_mem_wdata", mem_wdata,     32'hCAFE_F00D);
      chk("wr_mem_addr",  32'(mem_addr), 32'h8);
      chk("wr_stall",     32'(stall),    32'h1);
      cpu_addr = 32'h0000_1000 + 32'(i); cpu_wdata = 32'h1111_0000 + 32'(i); cpu_we = 1'b0;
      if (i == 5) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      end
      cyc();
    end
    chk("wr_done",  32'(cpu_done), 32'h1);
    chk("wr_rdata", cpu_rdata,     32'h1234_5678);
    chk("wr_we_dn", 32'(mem_we),   32'h0);
    cpu_req = 1'b0; mem_ack = 1'b0;
    cyc();

    // Misaligned read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0006;
    cyc();
    chk("mis_done",    32'(cpu_done), 32'h1);
    chk("mis_mem_req", 32'(mem_req),  32'h0);
    chk("mis_err",     32'(err),      32'h1);
    chk("mis_rdata",   cpu_rdata,     32'h1234_5678);
    cpu_req = 1'b0;
    cyc();
    chk("mis_done_off", 32'(cpu_done), 32'h0);
    chk("mis_req_off",  32'(mem_req),  32'h0);
    cyc();
    chk("mis_err_held", 32'(err), 32'h1);

    // Back-to-back: request held through cpu_done.
    cpu_req = 1'b1; cpu_addr = 32'h0000_0040;
    cyc();
    chk("b2b_addr1", 32'(mem_addr), 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0001;
    cyc();
    chk("b2b_done1",  32'(cpu_done), 32'h1);
    chk("b2b_rdata1", cpu_rdata,     32'h0BAD_0001);
    mem_ack = 1'b0; cpu_addr = 32'h0000_0044;
    cyc();
    chk("b2b_idle_stall", 32'(stall),    32'h1);
    chk("b2b_idle_done",  32'(cpu_done), 32'h0);
    chk("b2b_idle_req",   32'(mem_req),  32'h0);
    cyc();
    chk("b2b_req2",  32'(mem_req),  32'h1);
    chk("b2b_addr2", 32'(mem_addr), 32'h11);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0002;
    cyc();
    chk("b2b_done2",  32'(cpu_done), 32'h1);
    chk("b2b_rdata2", cpu_rdata,     32'h0BAD_0002);
    cpu_req = 1'b0; mem_ack = 1'b0;
    cyc();

    // Reset in the second REQ cycle.
    cpu_req = 1'b1; cpu_addr = 32'h0000_0030;
    cyc();
    cyc();
    chk("rr_req_before", 32'(mem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rr_req_async", 32'(mem_req),  32'h0);
    chk("rr_err",       32'(err),      32'h0);
    chk("rr_done",      32'(cpu_done), 32'h0);
    cpu_req = 1'b0;
    cyc();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    cyc();
    chk("rr_late_ack_done",  32'(cpu_done), 32'h0);
    chk("rr_late_ack_rdata", cpu_rdata,     32'h0);
    chk("rr_late_ack_req",   32'(mem_req),  32'h0);
    mem_ack = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h0000_0034;
    cyc();
    chk("rr_next_addr", 32'(mem_addr), 32'hD);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    cyc();
    chk("rr_next_done",  32'(cpu_done), 32'h1);
    chk("rr_next_rdata", cpu_rdata,     32'h0000_0077);
    chk("rr_next_err",   32'(err),      32'h0);
    cpu_req = 1'b0; mem_ack = 1'b0;
    cyc();

    // Read that is never acknowledged.
    cpu_req = 1'b1; cpu_addr = 32'h0000_0080;
    cyc();
`ifdef MEM_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < int'(TO); i++) begin
      chk("to_mem_req", 32'(mem_req),  32'h1);
      chk("to_no_done", 32'(cpu_done), 32'h0);
      cyc();
    end
    chk("to_done",     32'(cpu_done), 32'h1);
    chk("to_req_drop", 32'(mem_req),  32'h0);
    chk("to_err",      32'(err),      32'h1);
    chk("to_rdata",    cpu_rdata,     32'h0000_0077);
    cpu_req = 1'b0;
    cyc();
    chk("to_done_once", 32'(cpu_done), 32'h0);
`else
    for (int i = 0; i < 20; i++) cyc();
    chk("nto_mem_req", 32'(mem_req),  32'h1);
    chk("nto_err",     32'(err),      32'h0);
    chk("nto_done",    32'(cpu_done), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
    cyc();
    chk("nto_late_done", 32'(cpu_done), 32'h1);
    chk("nto_rdata",     cpu_rdata,     32'h0000_0099);
    cpu_req = 1'b0; mem_ack = 1'b0;
    cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
